// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants, scan mode type and width helpers for seg_scan_ctrl
package seg_scan_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic {IDLE, SCAN} mode_t;
  function automatic int width_of(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [7:0] an_off(int w);
    return 8'((1 << w) - 1);
  endfunction
endpackage

// File: rtl/bin_to_7seg.sv
// bin_to_7seg: hex nibble to active-low {g..a} segments, 0xD-0xF blank
module bin_to_7seg (
  input  logic [3:0] bin,
  output logic [6:0] seg
);
  // one glyph per nibble value
  always_comb begin
    case (bin)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered multiplexed 7-seg scanner; SEG_SCAN_LZB_EN enables leading-zero blanking
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);
  localparam int CNT_W = width_of(REFRESH_DIV);
  localparam int IDX_W = width_of(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_ALL = NUM_DIGITS'(an_off(NUM_DIGITS));
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [4*NUM_DIGITS-1:0] stg_d, act_d;
  logic [NUM_DIGITS-1:0] stg_dp, act_dp, lz;
  logic pending, last_cnt, boundary, commit, hide;
  logic [3:0] nib;
  logic [6:0] dec;
  mode_t mode;
  // scan mode, frame boundary and per-dwell blanking decision
  always_comb begin
    mode = en ? SCAN : IDLE;
    last_cnt = cnt == CNT_W'(REFRESH_DIV - 1);
    boundary = mode == SCAN && last_cnt && idx == IDX_W'(NUM_DIGITS - 1);
    commit = boundary && (pending || load);
    nib = act_d[4*idx +: 4];
    hide = cnt < CNT_W'(BLANK_CYCLES) || lz[idx];
  end
`ifdef SEG_SCAN_LZB_EN
  logic z;
  // a digit hides while it and every digit above it are zero; digit 0 never hides
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z && act_d[4*i +: 4] == 4'd0;
      lz[i] = z;
    end
  end
`else
  assign lz = '0;
`endif
  bin_to_7seg u_dec (.bin(nib), .seg(dec));
  // dwell counter and digit index, parked at zero while idle
  always_ff @(posedge clk) begin
    if (rst || mode == IDLE) begin
      cnt <= '0;
      idx <= '0;
    end else if (last_cnt) begin
      cnt <= '0;
      idx <= idx == IDX_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else cnt <= cnt + 1'b1;
  end
  // staging/active buffers: active only changes at a frame boundary or while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_d <= '0;
      stg_dp <= '0;
      act_d <= '0;
      act_dp <= '0;
      pending <= 1'b0;
    end else if (load && mode == IDLE) begin
      stg_d <= digits_in;
      stg_dp <= dp_in;
      act_d <= digits_in;
      act_dp <= dp_in;
      pending <= 1'b0;
    end else if (commit) begin
      stg_d <= load ? digits_in : stg_d;
      stg_dp <= load ? dp_in : stg_dp;
      act_d <= load ? digits_in : stg_d;
      act_dp <= load ? dp_in : stg_dp;
      pending <= 1'b0;
    end else if (load) begin
      stg_d <= digits_in;
      stg_dp <= dp_in;
      pending <= 1'b1;
    end
  end
  // registered display outputs, one cycle behind the (idx, cnt) that selects them
  always_ff @(posedge clk) begin
    if (rst || mode == IDLE) begin
      an <= AN_ALL;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an <= hide ? AN_ALL : ~(NUM_DIGITS'(1) << idx);
      seg <= hide ? SEG_BLANK : dec;
      dp <= hide || !act_dp[idx];
      frame_done <= boundary;
    end
  end
endmodule
